// File: rtl/rom.sv
// Program store for the 4-bit cpu: 32x8 words, combinational read at the PC.
// Define ROM_LOAD_EN to add a write port and reset re-imaging of the contents.
module rom #(
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DATA_W = 8
) (
  output logic [DATA_W-1:0] dout,
  input  logic [ADDR_W-1:0] addr,
  input  logic              clk,
  input  logic              reset
`ifdef ROM_LOAD_EN
  ,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data
`endif
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  // Default image: LED counter (SET 0; INC r0; MOV r6,r0; JMP 1), NOPs after.
  function automatic logic [DATA_W-1:0] image_word(input logic [ADDR_W-1:0] a);
    logic [DATA_W-1:0] w;
    w = '0;
    case (a)
      ADDR_W'(0): w = DATA_W'(8'hA0);
      ADDR_W'(1): w = DATA_W'(8'h60);
      ADDR_W'(2): w = DATA_W'(8'h30);
      ADDR_W'(3): w = DATA_W'(8'h91);
      default:    w = '0;
    endcase
    return w;
  endfunction

`ifdef ROM_LOAD_EN

  // Power-up contents match the default image.
  logic [DATA_W-1:0] mem_q [DEPTH] = '{
    DATA_W'(8'hA0), DATA_W'(8'h60), DATA_W'(8'h30), DATA_W'(8'h91), default: '0
  };
  logic [DATA_W-1:0] mem_d [DEPTH];

  // Reset re-images every word and wins over a simultaneous write.
  always_comb begin
    for (int i = 0; i < int'(DEPTH); i++) begin
      mem_d[i] = mem_q[i];
    end
    if (!reset) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_d[i] = image_word(ADDR_W'(i));
      end
    end else if (wr_en) begin
      mem_d[wr_addr] = wr_data;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < int'(DEPTH); i++) begin
      mem_q[i] <= mem_d[i];
    end
  end

  assign dout = mem_q[addr];

`else

  // Constant table; clock and reset have no function in this build.
  logic unused_clk_reset;
  assign unused_clk_reset = clk ^ reset;

  assign dout = image_word(addr);

`endif

endmodule

// File: tb/tb_rom.sv
// Directed bench for rom: image sweep, reset/clock independence, and (with
// ROM_LOAD_EN) write latency, reset re-imaging and reset-over-write priority.
module tb_rom;

  logic [7:0] dout;
  logic [4:0] addr;
  logic       clk;
  logic       reset;
`ifdef ROM_LOAD_EN
  logic       wr_en;
  logic [4:0] wr_addr;
  logic [7:0] wr_data;
`endif

  int vectors;
  int miscompares;

  rom dut (
    .dout    (dout),
    .addr    (addr),
    .clk     (clk),
    .reset   (reset)
`ifdef ROM_LOAD_EN
    ,
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] golden(input int a);
    case (a)
      0:       return 8'hA0;
      1:       return 8'h60;
      2:       return 8'h30;
      3:       return 8'h91;
      default: return 8'h00;
    endcase
  endfunction

  task automatic check(input string tag, input logic [7:0] exp);
    vectors++;
    assert (dout === exp) else begin
      miscompares++;
      $error("FAIL %s: addr=%0d observed %h expected %h", tag, addr, dout, exp);
    end
  endtask

  task automatic read_at(input string tag, input int a, input logic [7:0] exp);
    addr = 5'(a);
    #1;
    check(tag, exp);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    addr        = '0;
    reset       = 1'b1;
`ifdef ROM_LOAD_EN
    wr_en   = 1'b0;
    wr_addr = '0;
    wr_data = '0;
`endif

    // Power-up image, swept before any clock edge.
    for (int a = 0; a < 32; a++) begin
      read_at("powerup_sweep", a, golden(a));
    end

    // Reset low for one edge, then a few free-running cycles.
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    read_at("after_reset_a0", 0, 8'hA0);
    read_at("after_reset_a3", 3, 8'h91);
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    // PC trace of the image: 0,1,2,3 then JMP back to 1.
    read_at("trace_set", 0, 8'hA0);
    read_at("trace_inc", 1, 8'h60);
    read_at("trace_mov", 2, 8'h30);
    read_at("trace_jmp", 3, 8'h91);
    read_at("trace_nop_top", 31, 8'h00);

`ifdef ROM_LOAD_EN
    // Write to the word being fetched: old data until the edge, new after.
    @(negedge clk);
    addr    = 5'd2;
    wr_en   = 1'b1;
    wr_addr = 5'd2;
    wr_data = 8'h55;
    #1;
    check("wr_before_edge", 8'h30);
    @(posedge clk);
    #1;
    check("wr_after_edge", 8'h55);
    @(negedge clk);
    wr_en = 1'b0;

    // Overwrite word 31, then reset re-images everything.
    wr_en   = 1'b1;
    wr_addr = 5'd31;
    wr_data = 8'hFF;
    @(posedge clk);
    #1;
    @(negedge clk);
    wr_en = 1'b0;
    read_at("wr31_written", 31, 8'hFF);
    reset = 1'b0;
    @(posedge clk);
    #1;
    read_at("reimage_a31", 31, 8'h00);
    read_at("reimage_a0", 0, 8'hA0);
    read_at("reimage_a2", 2, 8'h30);
    @(negedge clk);
    reset = 1'b1;

    // Reset and write on the same edge: the write is dropped.
    @(negedge clk);
    reset   = 1'b0;
    wr_en   = 1'b1;
    wr_addr = 5'd5;
    wr_data = 8'h12;
    @(posedge clk);
    #1;
    read_at("reset_beats_write", 5, 8'h00);
    @(negedge clk);
    reset = 1'b1;
    wr_en = 1'b0;

    // Idle write port toggling must not disturb contents.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      wr_addr = 5'(i);
      wr_data = 8'(8'hC3 ^ i);
    end
    @(posedge clk);
    #1;
    for (int a = 0; a < 6; a++) begin
      read_at("idle_port", a, golden(a));
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
